paddle_ctrl: RTL and testbench
==============================

Name: paddle_ctrl

Overview:
Generalised paddle position controller for the breakout game.
- Moves a paddle centre coordinate left/right once per frame tick, from two direction buttons.
- Supports constant-speed and accelerating modes, parametrised screen and paddle geometry, and an explicit recenter command.
- Clamps the paddle at both walls with no wrap-around and no underflow.
- Feeds the VGA drawing path and the ball/paddle collision logic.

Parameters:
X_W, 10, width of all x coordinates
SCREEN_W, 640, visible screen width in pixels
PADDLE_HALF, 40, half paddle width; the paddle spans x_pos-PADDLE_HALF .. x_pos+PADDLE_HALF
RESET_X, 320, centre after reset or recenter
SPEED_MIN, 1, pixels per tick on first movement tick
SPEED_MAX, 4, speed ceiling
ACCEL_TICKS, 8, same-direction ticks per speed increment
MODE, 1, 0 = constant SPEED_MIN, 1 = accelerating
SPD_W, 4, width of speed output
Legal parameter range: PADDLE_HALF <= RESET_X <= SCREEN_W-1-PADDLE_HALF; SCREEN_W <= 2^X_W; 1 <= SPEED_MIN <= SPEED_MAX < 2^SPD_W.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse; movement is evaluated only on this pulse
move_left  in  1  active-high left request, asynchronous to clk
move_right  in  1  active-high right request, asynchronous to clk
recenter  in  1  synchronous one-cycle request to return to RESET_X
x_pos  out  X_W  registered paddle centre
x_left  out  X_W  x_pos - PADDLE_HALF
x_right  out  X_W  x_pos + PADDLE_HALF
at_left_wall  out  1  x_pos == PADDLE_HALF
at_right_wall  out  1  x_pos == SCREEN_W-1-PADDLE_HALF
speed  out  SPD_W  current speed; 0 when IDLE

Behaviour:
Reset (resetn low, asynchronous):
- x_pos=RESET_X, state IDLE, speed=0, accel counter=0, sync flops=0.
- Outputs take effect immediately and do not wait for a clk edge.

Input synchronisation:
- move_left/move_right pass through a 2-flop synchroniser.
- A press must be stable at least 2 clk edges before a tick to be seen at that tick.

Direction decode on a tick (synchronised inputs):
- L only -> LEFT; R only -> RIGHT; both or neither -> NONE.

States: IDLE, MOVE_L, MOVE_R. All updates happen only on cycles with frame_tick=1.
- Priority 1, recenter=1 (with or without a tick): x_pos=RESET_X, state IDLE, speed=0, counter=0.
- Priority 2, dir NONE: state IDLE, speed=0, counter=0, x_pos unchanged.
- Priority 3, dir differs from current state (entry or reversal): state = new direction, speed=SPEED_MIN, counter=0, x moves by SPEED_MIN.
- Priority 4, dir same as current state:
  - x moves by the current (pre-update) speed.
  - If MODE=1 and counter==ACCEL_TICKS-1: counter=0 and speed=min(speed+1, SPEED_MAX).
  - Otherwise counter=counter+1 (saturating). In MODE=0 speed stays SPEED_MIN.

Arithmetic and clamping:
- Evaluate in X_W+1 bits signed-safe.
- Left: new = x_pos - speed; if new < PADDLE_HALF then new = PADDLE_HALF. There is never an unsigned wrap.
- Right: new = x_pos + speed; if new > SCREEN_W-1-PADDLE_HALF then new = SCREEN_W-1-PADDLE_HALF.
- Clamping does not alter state or speed.

Outputs:
- x_left, x_right, at_left_wall and at_right_wall are combinational from registered x_pos and always consistent with it.
- Latency: one clk from the tick edge to the updated x_pos.
- No tick means no change, except for recenter.

Test Plan:
- Reset mid-movement: hold right for 5 ticks, then pull resetn low between clk edges -> x_pos=320 and speed=0 immediately; x_left=280, x_right=360, both wall flags 0.
- Acceleration, defaults, hold right from 320: after ticks 1..8 x_pos=321..328 with speed=1; tick 9 gives x_pos=329 and speed=2; tick 10 gives x_pos=331. No frame_tick for 100 clks -> x_pos unchanged.
- Left clamp/underflow, RESET_X=42, SPEED_MIN=4, hold left: tick 1 -> x_pos=40, at_left_wall=1, x_left=0; tick 2 -> still 40, no wrap to ~1020.
- Right clamp, RESET_X=597, SPEED_MIN=4, hold right: tick 1 -> x_pos=599, at_right_wall=1, x_right=639; further ticks hold at 599.
- Both/reversal: hold right 20 ticks (speed=3), release right and press left -> next tick speed=1 and x_pos decreases by 1. Press both buttons -> next tick speed=0, state IDLE, x_pos unchanged.
- Recenter and MODE=0: recenter asserted in the same cycle as frame_tick with right held -> x_pos=320, speed=0. With MODE=0, hold right 30 ticks -> speed stays 1 and x_pos=350.

Source files
------------

// File: rtl/paddle_ctrl.sv
// Breakout paddle centre controller: moves once per frame tick from two synchronised buttons,
// with optional acceleration, wall clamping and a recenter command.
module paddle_ctrl #(
    parameter int X_W         = 10,
    parameter int SCREEN_W    = 640,
    parameter int PADDLE_HALF = 40,
    parameter int RESET_X     = 320,
    parameter int SPEED_MIN   = 1,
    parameter int SPEED_MAX   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int MODE        = 1,
    parameter int SPD_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             move_left,
    input  logic             move_right,
    input  logic             recenter,
    output logic [X_W-1:0]   x_pos,
    output logic [X_W-1:0]   x_left,
    output logic [X_W-1:0]   x_right,
    output logic             at_left_wall,
    output logic             at_right_wall,
    output logic [SPD_W-1:0] speed
);

    localparam int CNT_W = $clog2(ACCEL_TICKS) + 1;

    localparam logic [X_W:0]       X_LO     = (X_W+1)'(PADDLE_HALF);
    localparam logic [X_W:0]       X_HI     = (X_W+1)'(SCREEN_W - 1 - PADDLE_HALF);
    localparam logic [X_W-1:0]     X_RST    = X_W'(RESET_X);
    localparam logic [X_W-1:0]     X_HALF   = X_W'(PADDLE_HALF);
    localparam logic [SPD_W-1:0]   SPD_LO   = SPD_W'(SPEED_MIN);
    localparam logic [SPD_W-1:0]   SPD_HI   = SPD_W'(SPEED_MAX);
    localparam logic [CNT_W-1:0]   CNT_WRAP = CNT_W'(ACCEL_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT  = '1;

    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_dir;
    logic             r_l_meta, r_l_sync, r_r_meta, r_r_sync;
    logic [X_W-1:0]   r_x_pos, w_x_nxt;
    logic [SPD_W-1:0] r_speed, w_spd_nxt, w_step;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [X_W:0]     w_x_ext, w_step_ext, w_x_dec, w_x_sum, w_x_inc;

    // Buttons are asynchronous to clk: two flops before anything decodes them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_l_meta <= 1'b0;
            r_l_sync <= 1'b0;
            r_r_meta <= 1'b0;
            r_r_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop samples the previous stage's old value.
            r_l_meta <= move_left;
            r_l_sync <= r_l_meta;
            r_r_meta <= move_right;
            r_r_sync <= r_r_meta;
        end
    end

    assign w_dir = (r_l_sync && !r_r_sync) ? MOVE_L :
                   (r_r_sync && !r_l_sync) ? MOVE_R : IDLE;

    // Entry or reversal moves by SPEED_MIN; continuing moves by the pre-update speed.
    assign w_step     = (w_dir == r_state) ? r_speed : SPD_LO;
    assign w_step_ext = (X_W+1)'(w_step);
    assign w_x_ext    = {1'b0, r_x_pos};
    assign w_x_dec    = (w_x_ext < X_LO + w_step_ext) ? X_LO : w_x_ext - w_step_ext;
    assign w_x_sum    = w_x_ext + w_step_ext;
    assign w_x_inc    = (w_x_sum > X_HI) ? X_HI : w_x_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (recenter)        w_state_nxt = IDLE;
        else if (frame_tick) w_state_nxt = w_dir;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_x_nxt   = r_x_pos;
        w_spd_nxt = r_speed;
        w_cnt_nxt = r_cnt;
        if (recenter) begin
            w_x_nxt   = X_RST;
            w_spd_nxt = '0;
            w_cnt_nxt = '0;
        end else if (frame_tick) begin
            if (w_dir == IDLE) begin
                w_spd_nxt = '0;
                w_cnt_nxt = '0;
            end else begin
                w_x_nxt = (w_dir == MOVE_L) ? w_x_dec[X_W-1:0] : w_x_inc[X_W-1:0];
                if (w_dir != r_state) begin
                    w_spd_nxt = SPD_LO;
                    w_cnt_nxt = '0;
                end else if (MODE == 1 && r_cnt == CNT_WRAP) begin
                    w_cnt_nxt = '0;
                    w_spd_nxt = (r_speed < SPD_HI) ? r_speed + 1'b1 : SPD_HI;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x_pos <= X_RST;
            r_speed <= '0;
            r_cnt   <= '0;
        end else begin
            r_x_pos <= w_x_nxt;
            r_speed <= w_spd_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign x_pos         = r_x_pos;
    assign x_left        = r_x_pos - X_HALF;
    assign x_right       = r_x_pos + X_HALF;
    assign at_left_wall  = (w_x_ext == X_LO);
    assign at_right_wall = (w_x_ext == X_HI);
    assign speed         = r_speed;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: default, left-clamp, right-clamp and constant-speed
// instances share one stimulus stream; each sequence checks the instance it targets.
module tb_paddle_ctrl;

    logic clk = 1'b0;
    logic resetn, frame_tick, move_left, move_right, recenter;

    logic [9:0] x_d,  xl_d,  xr_d,  x_lc, xl_lc, xr_lc, x_rc, xl_rc, xr_rc, x_m0, xl_m0, xr_m0;
    logic       lw_d, rw_d, lw_lc, rw_lc, lw_rc, rw_rc, lw_m0, rw_m0;
    logic [3:0] sp_d, sp_lc, sp_rc, sp_m0;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit    ml;
        bit    mr;
        bit    rc;
        int    idle;
        int    exp_x;
        int    exp_spd;
        string name;
    } vec_t;

    vec_t vecs[24];

    always #5 clk = ~clk;

    paddle_ctrl u_def (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .move_left(move_left),
        .move_right(move_right), .recenter(recenter), .x_pos(x_d), .x_left(xl_d),
        .x_right(xr_d), .at_left_wall(lw_d), .at_right_wall(rw_d), .speed(sp_d)
    );

    paddle_ctrl #(.RESET_X(42), .SPEED_MIN(4)) u_lc (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .move_left(move_left),
        .move_right(move_right), .recenter(recenter), .x_pos(x_lc), .x_left(xl_lc),
        .x_right(xr_lc), .at_left_wall(lw_lc), .at_right_wall(rw_lc), .speed(sp_lc)
    );

    paddle_ctrl #(.RESET_X(597), .SPEED_MIN(4)) u_rc (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .move_left(move_left),
        .move_right(move_right), .recenter(recenter), .x_pos(x_rc), .x_left(xl_rc),
        .x_right(xr_rc), .at_left_wall(lw_rc), .at_right_wall(rw_rc), .speed(sp_rc)
    );

    paddle_ctrl #(.MODE(0)) u_m0 (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .move_left(move_left),
        .move_right(move_right), .recenter(recenter), .x_pos(x_m0), .x_left(xl_m0),
        .x_right(xr_m0), .at_left_wall(lw_m0), .at_right_wall(rw_m0), .speed(sp_m0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        frame_tick = 1'b0;
        recenter   = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Three clk edges of stable level so the synchroniser output is settled before the next tick.
    task automatic set_buttons(input bit l, input bit r);
        move_left  = l;
        move_right = r;
        repeat (3) @(negedge clk);
    endtask

    task automatic step(input bit rc);
        frame_tick = 1'b1;
        recenter   = rc;
        @(negedge clk);
        frame_tick = 1'b0;
        recenter   = 1'b0;
    endtask

    function automatic vec_t mk(input bit ml, input bit mr, input bit rc, input int idle,
                                input int ex, input int es, input string nm);
        vec_t v;
        v.ml = ml; v.mr = mr; v.rc = rc; v.idle = idle;
        v.exp_x = ex; v.exp_spd = es; v.name = nm;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit cur_l, cur_r;
        int ex, es;

        // Hold right from 320: speed 1 for ticks 1..8, 2 for 9..16, 3 from 17 on.
        for (int k = 1; k <= 20; k++) begin
            if (k <= 9) begin
                ex = 320 + k;
                es = (k <= 8) ? 1 : 2;
            end else if (k <= 17) begin
                ex = 329 + 2 * (k - 9);
                es = (k <= 16) ? 2 : 3;
            end else begin
                ex = 345 + 3 * (k - 17);
                es = 3;
            end
            vecs[k-1] = mk(1'b0, 1'b1, 1'b0, (k == 10) ? 100 : 0, ex, es, $sformatf("right_t%0d", k));
        end
        vecs[20] = mk(1'b1, 1'b0, 1'b0, 0, 353, 1, "reverse_left");
        vecs[21] = mk(1'b1, 1'b1, 1'b0, 0, 353, 0, "both_idle");
        vecs[22] = mk(1'b0, 1'b1, 1'b1, 0, 320, 0, "recenter_with_tick");
        vecs[23] = mk(1'b0, 1'b1, 1'b0, 0, 321, 1, "right_after_recenter");

        do_reset();
        check("reset_x", x_d, 320);
        check("reset_speed", sp_d, 0);
        check("reset_x_left", xl_d, 280);
        check("reset_x_right", xr_d, 360);

        cur_l = 1'b0;
        cur_r = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (vecs[i].ml != cur_l || vecs[i].mr != cur_r) begin
                set_buttons(vecs[i].ml, vecs[i].mr);
                cur_l = vecs[i].ml;
                cur_r = vecs[i].mr;
            end
            step(vecs[i].rc);
            check({vecs[i].name, "_x"},       x_d,  vecs[i].exp_x);
            check({vecs[i].name, "_speed"},   sp_d, vecs[i].exp_spd);
            check({vecs[i].name, "_x_left"},  xl_d, vecs[i].exp_x - 40);
            check({vecs[i].name, "_x_right"}, xr_d, vecs[i].exp_x + 40);
            if (vecs[i].idle > 0) begin
                repeat (vecs[i].idle) @(negedge clk);
                check({vecs[i].name, "_no_tick_x"},     x_d,  vecs[i].exp_x);
                check({vecs[i].name, "_no_tick_speed"}, sp_d, vecs[i].exp_spd);
            end
        end

        // Asynchronous reset in the middle of movement, between clock edges.
        do_reset();
        set_buttons(1'b0, 1'b1);
        repeat (5) step(1'b0);
        check("pre_reset_x", x_d, 325);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_x", x_d, 320);
        check("async_reset_speed", sp_d, 0);
        check("async_reset_x_left", xl_d, 280);
        check("async_reset_x_right", xr_d, 360);
        check("async_reset_left_wall", lw_d, 0);
        check("async_reset_right_wall", rw_d, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Left clamp: 42 - 4 would be 38, so it clamps to 40 and never wraps.
        do_reset();
        set_buttons(1'b1, 1'b0);
        step(1'b0);
        check("lclamp_t1_x", x_lc, 40);
        check("lclamp_t1_wall", lw_lc, 1);
        check("lclamp_t1_x_left", xl_lc, 0);
        check("lclamp_t1_speed", sp_lc, 4);
        step(1'b0);
        check("lclamp_t2_x", x_lc, 40);
        check("lclamp_t2_x_left", xl_lc, 0);
        check("lclamp_t2_wall", lw_lc, 1);

        // Right clamp: 597 + 4 would be 601, so it clamps to 599.
        do_reset();
        set_buttons(1'b0, 1'b1);
        step(1'b0);
        check("rclamp_t1_x", x_rc, 599);
        check("rclamp_t1_wall", rw_rc, 1);
        check("rclamp_t1_x_right", xr_rc, 639);
        check("rclamp_t1_left_wall", lw_rc, 0);
        repeat (3) step(1'b0);
        check("rclamp_t4_x", x_rc, 599);
        check("rclamp_t4_wall", rw_rc, 1);

        // Constant-speed mode: 30 ticks at 1 pixel each.
        do_reset();
        set_buttons(1'b0, 1'b1);
        repeat (30) step(1'b0);
        check("mode0_x", x_m0, 350);
        check("mode0_speed", sp_m0, 1);

        // Buttons pressed but no tick: nothing moves.
        do_reset();
        set_buttons(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("no_tick_x", x_d, 320);
        check("no_tick_speed", sp_d, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
